// File: rtl/inst_sequencer.sv
// Instruction sequencer: 4-deep host queue feeding a fetch/exec timestep FSM.
// Presents queued words to the controller and counts retired instructions.
module inst_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] in_inst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       Ext,
  input  logic       Clr,
  output logic [1:0] T,
  output logic [9:0] Data,
  output logic       fetch_en,
  output logic [7:0] retired,
  output logic       empty,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [9:0] mem_q [4];
  logic [9:0] mem_d [4];
  logic [1:0] wptr_q, wptr_d;
  logic [1:0] rptr_q, rptr_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] t_q, t_d;
  logic       fetch_en_q, fetch_en_d;
  logic [7:0] retired_q, retired_d;
  logic       err_q, err_d;
  logic       push, pop, done;

  assign in_ready = (cnt_q != 3'd4);
  assign empty    = (cnt_q == 3'd0);
  assign T        = t_q;
  assign fetch_en = fetch_en_q;
  assign retired  = retired_q;
  assign err      = err_q;
  // Head word is only driven while the fetch flag is set.
  assign Data     = fetch_en_q ? mem_q[rptr_q] : 10'd0;

  always_comb begin
    push = in_valid && in_ready;
    pop  = (state_q == FETCH) && !empty;
    mem_d = mem_q;
    if (push) begin
      mem_d[wptr_q] = in_inst;
    end
    wptr_d = wptr_q + {1'b0, push};
    rptr_d = rptr_q + {1'b0, pop};
    cnt_d  = cnt_q + {2'b00, push} - {2'b00, pop};
  end

  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    fetch_en_d = 1'b0;
    retired_d  = retired_q;
    err_d      = err_q;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        t_d = 2'd0;
        if (Ext) err_d = 1'b1;
        if (cnt_d != 3'd0) begin
          state_d    = FETCH;
          fetch_en_d = 1'b1;
        end
      end
      FETCH: begin
        if (!Ext) err_d = 1'b1;
        t_d     = 2'd1;
        state_d = EXEC;
      end
      EXEC: begin
        if (Ext) err_d = 1'b1;
        done = Clr || (t_q == 2'd3);
        if (done) begin
          if (!Clr) err_d = 1'b1;
          t_d       = 2'd0;
          retired_d = retired_q + 8'd1;
          if (cnt_d != 3'd0) begin
            state_d    = FETCH;
            fetch_en_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          t_d = t_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        t_d     = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wptr_q     <= 2'd0;
      rptr_q     <= 2'd0;
      cnt_q      <= 3'd0;
      t_q        <= 2'd0;
      fetch_en_q <= 1'b0;
      retired_q  <= 8'd0;
      err_q      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= 10'd0;
      end
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      t_q        <= t_d;
      fetch_en_q <= fetch_en_d;
      retired_q  <= retired_d;
      err_q      <= err_d;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: inputs change just after a falling
// edge, outputs are sampled on the following falling edge.
module tb_inst_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] in_inst;
  logic       in_valid;
  logic       in_ready;
  logic       Ext;
  logic       Clr;
  logic [1:0] T;
  logic [9:0] Data;
  logic       fetch_en;
  logic [7:0] retired;
  logic       empty;
  logic       err;

  integer checks = 0;
  integer errors = 0;

  inst_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_inst  (in_inst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Ext      (Ext),
    .Clr      (Clr),
    .T        (T),
    .Data     (Data),
    .fetch_en (fetch_en),
    .retired  (retired),
    .empty    (empty),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_inst  = 10'd0;
    Ext      = 1'b0;
    Clr      = 1'b0;
    rst_n    = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({T, Data, fetch_en, retired, err} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outs got T=%0d D=%h fe=%b r=%0d e=%b want 0",
               T, Data, fetch_en, retired, err);
    end
    checks++;
    if ({empty, in_ready} !== 2'b11) begin
      errors++;
      $display("FAIL reset_flags got %b want 11", {empty, in_ready});
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_ld();
    do_reset();
    in_valid = 1'b1;
    in_inst  = 10'h082;
    step();
    checks++;
    if ({fetch_en, Data, T} !== {1'b1, 10'h082, 2'd0}) begin
      errors++;
      $display("FAIL ld_fetch got fe=%b D=%h T=%0d want 1 082 0",
               fetch_en, Data, T);
    end
    in_valid = 1'b0;
    Ext = 1'b1;
    step();
    checks++;
    if ({fetch_en, Data, T} !== {1'b0, 10'h000, 2'd1}) begin
      errors++;
      $display("FAIL ld_exec got fe=%b D=%h T=%0d want 0 000 1",
               fetch_en, Data, T);
    end
    Ext = 1'b0;
    Clr = 1'b1;
    step();
    Clr = 1'b0;
    checks++;
    if ({T, retired, fetch_en, empty, err} !== {2'd0, 8'd1, 3'b010}) begin
      errors++;
      $display("FAIL ld_done got T=%0d r=%0d fe=%b em=%b e=%b want 0 1 0 1 0",
               T, retired, fetch_en, empty, err);
    end
    step();
    checks++;
    if (fetch_en !== 1'b0) begin
      errors++;
      $display("FAIL ld_idle got fe=%b want 0", fetch_en);
    end
  endtask

  task automatic test_add();
    do_reset();
    in_valid = 1'b1;
    in_inst  = 10'h012;
    step();
    in_valid = 1'b0;
    checks++;
    if ({fetch_en, Data, T} !== {1'b1, 10'h012, 2'd0}) begin
      errors++;
      $display("FAIL add_fetch got fe=%b D=%h T=%0d want 1 012 0",
               fetch_en, Data, T);
    end
    Ext = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      Ext = 1'b0;
      checks++;
      if (T !== 2'(i)) begin
        errors++;
        $display("FAIL add_t%0d got T=%0d want %0d", i, T, i);
      end
    end
    Clr = 1'b1;
    step();
    Clr = 1'b0;
    checks++;
    if ({T, retired, err} !== {2'd0, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL add_done got T=%0d r=%0d e=%b want 0 1 0",
               T, retired, err);
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] exp_d [4];
    exp_d[0] = 10'h002;
    exp_d[1] = 10'h003;
    exp_d[2] = 10'h004;
    exp_d[3] = 10'h005;
    do_reset();
    in_valid = 1'b1;
    in_inst  = 10'h3FF;
    step();
    Ext     = 1'b1;
    in_inst = 10'h001;
    step();
    Ext     = 1'b0;
    in_inst = 10'h002;
    step();
    in_inst = 10'h003;
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready3 got %b want 1", in_ready);
    end
    in_inst = 10'h004;
    Clr = 1'b1;
    step();
    checks++;
    if ({in_ready, fetch_en, Data, retired} !== {2'b01, 10'h001, 8'd1}) begin
      errors++;
      $display("FAIL bp_full got rdy=%b fe=%b D=%h r=%0d want 0 1 001 1",
               in_ready, fetch_en, Data, retired);
    end
    Clr = 1'b0;
    Ext = 1'b1;
    in_inst = 10'h005;
    step();
    checks++;
    if ({in_ready, T, empty} !== {1'b1, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL bp_held got rdy=%b T=%0d em=%b want 1 1 0",
               in_ready, T, empty);
    end
    Ext = 1'b0;
    Clr = 1'b1;
    step();
    in_valid = 1'b0;
    Clr = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_refull got %b want 0", in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({fetch_en, Data} !== {1'b1, exp_d[i]}) begin
        errors++;
        $display("FAIL bp_order%0d got fe=%b D=%h want 1 %h",
                 i, fetch_en, Data, exp_d[i]);
      end
      Ext = 1'b1;
      step();
      Ext = 1'b0;
      Clr = 1'b1;
      step();
      Clr = 1'b0;
    end
    checks++;
    if ({fetch_en, empty, err, retired} !== {3'b010, 8'd6}) begin
      errors++;
      $display("FAIL bp_end got fe=%b em=%b e=%b r=%0d want 0 1 0 6",
               fetch_en, empty, err, retired);
    end
  endtask

  task automatic test_errors();
    do_reset();
    in_valid = 1'b1;
    in_inst  = 10'h055;
    step();
    in_valid = 1'b0;
    Ext = 1'b1;
    step();
    Ext = 1'b0;
    step();
    step();
    checks++;
    if ({T, err} !== {2'd3, 1'b0}) begin
      errors++;
      $display("FAIL err_t3 got T=%0d e=%b want 3 0", T, err);
    end
    step();
    checks++;
    if ({T, err, retired, fetch_en} !== {2'd0, 1'b1, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL err_timeout got T=%0d e=%b r=%0d fe=%b want 0 1 1 0",
               T, err, retired, fetch_en);
    end
    step();
    step();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got %b want 1", err);
    end
    do_reset();
    in_valid = 1'b1;
    in_inst  = 10'h066;
    step();
    in_valid = 1'b0;
    Ext = 1'b1;
    step();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_fresh got %b want 0", err);
    end
    step();
    Ext = 1'b0;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_ext_exec got %b want 1", err);
    end
    do_reset();
    in_valid = 1'b1;
    in_inst  = 10'h077;
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if ({err, empty, T} !== {2'b11, 2'd1}) begin
      errors++;
      $display("FAIL err_noext got e=%b em=%b T=%0d want 1 1 1",
               err, empty, T);
    end
  endtask

  task automatic test_clr_ignored();
    do_reset();
    Clr = 1'b1;
    step();
    checks++;
    if ({err, fetch_en} !== 2'b00) begin
      errors++;
      $display("FAIL clr_idle got e=%b fe=%b want 0 0", err, fetch_en);
    end
    in_valid = 1'b1;
    in_inst  = 10'h111;
    step();
    in_valid = 1'b0;
    Ext = 1'b1;
    step();
    Ext = 1'b0;
    Clr = 1'b0;
    checks++;
    if ({err, T, retired} !== {1'b0, 2'd1, 8'd0}) begin
      errors++;
      $display("FAIL clr_fetch got e=%b T=%0d r=%0d want 0 1 0",
               err, T, retired);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 1'b1;
    in_inst  = 10'h0A1;
    step();
    Ext     = 1'b1;
    in_inst = 10'h0A2;
    step();
    Ext     = 1'b0;
    in_inst = 10'h0A3;
    step();
    in_valid = 1'b0;
    checks++;
    if ({T, empty} !== {2'd2, 1'b0}) begin
      errors++;
      $display("FAIL rm_pre got T=%0d em=%b want 2 0", T, empty);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({T, Data, fetch_en, retired, err} !== 22'd0) begin
      errors++;
      $display("FAIL rm_outs got T=%0d D=%h fe=%b r=%0d e=%b want 0",
               T, Data, fetch_en, retired, err);
    end
    checks++;
    if ({empty, in_ready} !== 2'b11) begin
      errors++;
      $display("FAIL rm_flags got %b want 11", {empty, in_ready});
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (fetch_en !== 1'b0) begin
        errors++;
        $display("FAIL rm_nofetch%0d got %b want 0", i, fetch_en);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid = 1'b1;
    in_inst  = 10'h1C3;
    step();
    for (int i = 0; i < 256; i++) begin
      checks++;
      if ({fetch_en, retired} !== {1'b1, 8'(i)}) begin
        errors++;
        $display("FAIL b2b_%0d got fe=%b r=%0d want 1 %0d",
                 i, fetch_en, retired, i[7:0]);
      end
      Ext = 1'b1;
      step();
      Ext = 1'b0;
      Clr = 1'b1;
      step();
      Clr = 1'b0;
    end
    in_valid = 1'b0;
    checks++;
    if ({retired, err, fetch_en} !== {8'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL b2b_wrap got r=%0d e=%b fe=%b want 0 0 1",
               retired, err, fetch_en);
    end
  endtask

  initial begin
    test_reset();
    test_ld();
    test_add();
    test_backpressure();
    test_errors();
    test_clr_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_sequencer.md
INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_inst  input  10  instruction word pushed by the host.
REQ-005 in_valid  input  1  host push request.
REQ-006 in_ready  output  1  queue can accept a word; equals !full.
REQ-007 Ext  input  1  controller fetch strobe, meaning the controller drives the bus from external data.
REQ-008 Clr  input  1  controller end-of-instruction strobe.
REQ-009 T  output  2  timestep presented to the controller.
REQ-010 Data  output  10  instruction word presented on the external data input.
REQ-011 fetch_en  output  1  Data is valid for this cycle's instruction-register load.
REQ-012 retired  output  8  count of completed instructions.
REQ-013 empty  output  1  queue holds 0 entries.
REQ-014 err  output  1  sticky protocol-error flag.

Function
REQ-015 Queue: 4-entry FIFO with 2-bit read/write pointers that wrap 3->0, and a 3-bit occupancy count (0..4).
REQ-016 Push: a push occurs iff in_valid && in_ready at a rising edge; the word is written at the write pointer.
REQ-017 With in_valid high and in_ready low, the word SHALL NOT be written, and the queue, pointers and count SHALL be unchanged.
REQ-018 Pop: occurs only on the FETCH cycle.
  - Simultaneous push and pop: count unchanged, both pointers advance.
REQ-019 FSM states: IDLE, FETCH, EXEC.
REQ-020 IDLE:
  - T=0, fetch_en=0, Data=0.
  - Go to FETCH on the first edge where the occupancy count is nonzero, including an entry pushed that same edge.
  - Latency: push at edge n, fetch_en high in cycle n+1.
REQ-021 FETCH:
  - T=0, fetch_en=1, Data=head entry.
  - At the edge, pop the head, set T=1, go to EXEC.
REQ-022 FETCH without Ext high SHALL set err; the pop still occurs.
REQ-023 EXEC:
  - Data=0, fetch_en=0.
  - Without Clr, T increments by 1 per edge.
  - With Clr at the edge: T->0, retired increments, next state is FETCH if the post-edge count is nonzero, else IDLE.
REQ-024 EXEC with T=3 and Clr low SHALL set err, force T->0, increment retired, and apply the REQ-023 next-state rule.
REQ-025 Ext high in any state other than FETCH SHALL set err.
REQ-026 Clr high in IDLE or FETCH SHALL be ignored and SHALL NOT set err.
REQ-027 retired SHALL be 8-bit and wrap 255->0.
REQ-028 err SHALL stay set until reset.
REQ-029 All outputs except in_ready and empty SHALL be registered or decoded from registered state only, with no combinational path from Ext or Clr.

Reset
REQ-030 While rst_n is low, regardless of clk:
  - T=0, Data=0, fetch_en=0, retired=0, err=0.
  - empty=1, in_ready=1, queue count=0, pointers=0.
  - state=IDLE.
REQ-031 Reset asserted mid-instruction or with a full queue SHALL discard all queued words; no partial retire is counted.
REQ-032 The first push after rst_n deasserts SHALL be accepted on the first rising edge.

Verification
REQ-033 Push 0x082 (ld-type) at edge 0; controller pulses Ext at T=0 and Clr at T=1 -> fetch_en high in cycle 1 with Data=0x082; T sequence 0,1,0; retired=1; back to IDLE; err=0.
REQ-034 Push 0x012 (add) with Clr at T=3 -> T sequence 0,1,2,3,0; retired=1.
REQ-035 Hold in_valid high with words 0x001..0x005 while the sequencer is stalled in EXEC -> in_ready drops after 4 accepted words; 0x005 is held and accepted after the next pop; fetch order is 0x001..0x005.
REQ-036 EXEC reaches T=3 with Clr low -> err=1 stays set, T=0, retired increments; an Ext pulse in EXEC on a fresh run -> err=1.
REQ-037 Queue 3 words, run to T=2, pull rst_n low between edges -> outputs reach reset values immediately, empty=1, and no queued word is fetched after release.
REQ-038 Retire 256 instructions back-to-back -> retired wraps to 0; FETCH follows Clr with no idle cycle while the queue is nonempty.
